// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - one requester's valid/grant and response bundle; lock line exists only with DMEM_ARB_LOCK_EN
interface dmem_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
`ifdef DMEM_ARB_LOCK_EN
    logic        lock;
`endif
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

`ifdef DMEM_ARB_LOCK_EN
    modport master (output req, we, addr, wdata, lock, input  gnt, rvalid, rdata, err);
    modport slave  (input  req, we, addr, wdata, lock, output gnt, rvalid, rdata, err);
`else
    modport master (output req, we, addr, wdata, input  gnt, rvalid, rdata, err);
    modport slave  (input  req, we, addr, wdata, output gnt, rvalid, rdata, err);
`endif
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin data memory arbiter; optional ownership lock under DMEM_ARB_LOCK_EN
module dmem_arbiter #(
    parameter int unsigned NUM_WORDS = 1024
`ifdef DMEM_ARB_LOCK_EN
   ,parameter int unsigned LOCK_MAX  = 16
`endif
) (
    input  logic          clk_i,
    input  logic          rst_i,
    dmem_arbiter_if.slave r0_s,
    dmem_arbiter_if.slave r1_s,
    output logic          mem_wr_o,
    output logic          mem_read_o,
    output logic [31:0]   mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    input  logic [31:0]   mem_rdata_i
);

`ifdef DMEM_ARB_LOCK_EN
    localparam int unsigned CNT_W = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_MAX - 1);

    typedef enum logic {ST_ARB, ST_LOCKED} state_e;

    state_e           state_q;
    logic             owner_q;
    logic [CNT_W-1:0] lock_cnt_q;
    logic             win_lock;
`endif

    logic        rr_ptr_q;
    logic        resp_valid_q;
    logic        resp_id_q;
    logic        resp_err_q;
    logic        resp_we_q;
    logic [31:0] resp_wdata_q;

    logic        any_req;
    logic        win_id;
    logic        grant;
    logic        win_we;
    logic [31:0] win_addr;
    logic [31:0] win_wdata;
    logic        in_range;
    logic        mem_go;
    logic [31:0] resp_data;

    // Pick the winner: round-robin in ARB, owner only while locked
    always_comb begin
        any_req = r0_s.req | r1_s.req;
        win_id  = (r0_s.req && r1_s.req) ? rr_ptr_q : r1_s.req;
`ifdef DMEM_ARB_LOCK_EN
        if (state_q == ST_LOCKED) begin
            any_req = owner_q ? r1_s.req : r0_s.req;
            win_id  = owner_q;
        end
`endif
    end

    // Steer the winner's fields to memory; out-of-range accesses never strobe it
    always_comb begin
        grant     = any_req && !rst_i;
        win_we    = win_id ? r1_s.we    : r0_s.we;
        win_addr  = win_id ? r1_s.addr  : r0_s.addr;
        win_wdata = win_id ? r1_s.wdata : r0_s.wdata;
`ifdef DMEM_ARB_LOCK_EN
        win_lock  = win_id ? r1_s.lock  : r0_s.lock;
`endif
        in_range  = (win_addr < 32'(NUM_WORDS));
        mem_go    = grant && in_range;

        r0_s.gnt    = grant && !win_id;
        r1_s.gnt    = grant &&  win_id;
        mem_wr_o    = mem_go &&  win_we;
        mem_read_o  = mem_go && !win_we;
        mem_addr_o  = mem_go ? win_addr  : 32'd0;
        mem_wdata_o = mem_go ? win_wdata : 32'd0;
    end

    // Route the one-cycle-late response to whoever was granted last cycle
    always_comb begin
        if (resp_err_q)     resp_data = 32'd0;
        else if (resp_we_q) resp_data = resp_wdata_q;
        else                resp_data = mem_rdata_i;

        r0_s.rvalid = !rst_i && resp_valid_q && !resp_id_q;
        r1_s.rvalid = !rst_i && resp_valid_q &&  resp_id_q;
        r0_s.err    = r0_s.rvalid && resp_err_q;
        r1_s.err    = r1_s.rvalid && resp_err_q;
        r0_s.rdata  = r0_s.rvalid ? resp_data : 32'd0;
        r1_s.rdata  = r1_s.rvalid ? resp_data : 32'd0;
    end

    // Response pipeline, round-robin pointer and lock FSM
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_we_q    <= 1'b0;
            resp_wdata_q <= 32'd0;
`ifdef DMEM_ARB_LOCK_EN
            state_q      <= ST_ARB;
            owner_q      <= 1'b0;
            lock_cnt_q   <= '0;
`endif
        end else begin
            resp_valid_q <= grant;
            resp_id_q    <= win_id;
            resp_err_q   <= grant && !in_range;
            resp_we_q    <= win_we;
            resp_wdata_q <= win_wdata;
`ifdef DMEM_ARB_LOCK_EN
            case (state_q)
                ST_ARB: begin
                    if (grant) begin
                        rr_ptr_q <= ~win_id;
                        if (win_lock) begin
                            state_q    <= ST_LOCKED;
                            owner_q    <= win_id;
                            lock_cnt_q <= '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    // Release on an unlocking access or when the hold budget runs out
                    if ((grant && !win_lock) || (lock_cnt_q == LOCK_LAST)) begin
                        state_q    <= ST_ARB;
                        rr_ptr_q   <= ~owner_q;
                        lock_cnt_q <= '0;
                    end else begin
                        lock_cnt_q <= lock_cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_ARB;
            endcase
`else
            if (grant) rr_ptr_q <= ~win_id;
`endif
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - table-driven bench with response scoreboard for dmem_arbiter
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_wr;
    logic        mem_read;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;

    dmem_arbiter_if r0_if ();
    dmem_arbiter_if r1_if ();

    dmem_arbiter #(.NUM_WORDS(1024)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .r0_s        (r0_if),
        .r1_s        (r1_if),
        .mem_wr_o    (mem_wr),
        .mem_read_o  (mem_read),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int a);
        return (a == 5) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(a));
    endfunction

    // Registered single-port memory, preloaded on the first clock
    logic [31:0] mem [0:1023];
    logic        mem_init_q = 1'b0;
    always @(posedge clk) begin
        if (!mem_init_q) begin
            for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
            mem_init_q <= 1'b1;
        end else if (mem_wr) begin
            mem[mem_addr[9:0]] <= mem_wdata;
            mem_rdata          <= mem_wdata;
        end else if (mem_read) begin
            mem_rdata <= mem[mem_addr[9:0]];
        end
    end

    typedef struct {
        logic q0, w0; logic [31:0] a0, d0;
        logic q1, w1; logic [31:0] a1, d1;
        logic g0, g1, mwr, mrd; logic [31:0] maddr, mwdata;
    } vec_t;

    typedef struct {
        logic id; logic err; logic [31:0] data;
    } exp_t;

    vec_t        tbl [$];
    exp_t        sb  [$];
    logic [31:0] shadow [int];
    int          errors = 0;
    int          checks = 0;

    function automatic vec_t mk(input logic q0, w0, input logic [31:0] a0, d0,
                                input logic q1, w1, input logic [31:0] a1, d1,
                                input logic g0, g1, mwr, mrd, input logic [31:0] maddr, mwdata);
        vec_t v;
        v.q0 = q0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.q1 = q1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.mwr = mwr; v.mrd = mrd; v.maddr = maddr; v.mwdata = mwdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        r0_if.req = v.q0; r0_if.we = v.w0; r0_if.addr = v.a0; r0_if.wdata = v.d0;
        r1_if.req = v.q1; r1_if.we = v.w1; r1_if.addr = v.a1; r1_if.wdata = v.d1;
`ifdef DMEM_ARB_LOCK_EN
        r0_if.lock = 1'b0; r1_if.lock = 1'b0;
`endif
    endtask

    task automatic check_resp();
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rvalid_owner", e.id ? r1_if.rvalid : r0_if.rvalid, 32'd1);
            chk("rvalid_other", e.id ? r0_if.rvalid : r1_if.rvalid, 32'd0);
            chk("rdata_owner",  e.id ? r1_if.rdata  : r0_if.rdata,  e.data);
            chk("rdata_other",  e.id ? r0_if.rdata  : r1_if.rdata,  32'd0);
            chk("err_owner",    e.id ? r1_if.err    : r0_if.err,    32'(e.err));
        end else begin
            chk("r0_rvalid_idle", r0_if.rvalid, 32'd0);
            chk("r1_rvalid_idle", r1_if.rvalid, 32'd0);
        end
    endtask

    task automatic step(input vec_t v);
        exp_t        e;
        logic [31:0] a;
        @(posedge clk); #1;
        drive(v);
        @(negedge clk);
        check_resp();
        chk("r0_gnt",    r0_if.gnt, 32'(v.g0));
        chk("r1_gnt",    r1_if.gnt, 32'(v.g1));
        chk("mem_wr",    mem_wr,    32'(v.mwr));
        chk("mem_read",  mem_read,  32'(v.mrd));
        chk("mem_addr",  mem_addr,  v.maddr);
        chk("mem_wdata", mem_wdata, v.mwdata);
        if (v.g0 || v.g1) begin
            e.id  = v.g1;
            a     = v.g1 ? v.a1 : v.a0;
            e.err = (a >= 32'd1024);
            if (e.err)              e.data = 32'd0;
            else if (v.g1 ? v.w1 : v.w0) begin
                e.data = v.g1 ? v.d1 : v.d0;
                shadow[int'(a)] = e.data;
            end else                e.data = shadow.exists(int'(a)) ? shadow[int'(a)] : pat(int'(a));
            sb.push_back(e);
        end
    endtask

    initial begin
        vec_t idle;
        idle = mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0);

        // Contention and idle-pointer behaviour
        tbl.push_back(mk(1,0,5,0,           1,0,7,0,        1,0,0,1, 5,0));
        tbl.push_back(mk(1,0,5,0,           1,0,7,0,        0,1,0,1, 7,0));
        tbl.push_back(mk(1,0,5,0,           1,0,7,0,        1,0,0,1, 5,0));
        tbl.push_back(mk(1,0,5,0,           1,0,7,0,        0,1,0,1, 7,0));
        tbl.push_back(idle);
        // Write then read back from the other port
        tbl.push_back(mk(1,1,3,32'hA5A5A5A5, 0,0,0,0,        1,0,1,0, 3,32'hA5A5A5A5));
        tbl.push_back(mk(0,0,0,0,           1,0,3,0,        0,1,0,1, 3,0));
        // Address boundaries
        tbl.push_back(mk(0,0,0,0,           1,1,1024,32'h1234, 0,1,0,0, 0,0));
        tbl.push_back(mk(1,0,1023,0,        0,0,0,0,        1,0,0,1, 1023,0));
        tbl.push_back(mk(1,1,32'hFFFFFFFF,32'h55, 0,0,0,0,   1,0,0,0, 0,0));
        tbl.push_back(idle);
        // Idle cycle must not have rotated the pointer
        tbl.push_back(mk(1,0,0,0,           1,1,9,32'h99,   0,1,1,0, 9,32'h99));
        tbl.push_back(mk(1,0,0,0,           1,0,9,0,        1,0,0,1, 0,0));
        tbl.push_back(mk(0,0,0,0,           1,0,9,0,        0,1,0,1, 9,0));
        tbl.push_back(mk(1,0,5,32'hCAFE,    0,0,0,0,        1,0,0,1, 5,32'hCAFE));

        // Reset with a request pending: everything held quiet
        drive(mk(1,0,5,0, 1,1,6,32'h66, 0,0,0,0, 0,0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_r0_gnt",   r0_if.gnt,    32'd0);
        chk("rst_r1_gnt",   r1_if.gnt,    32'd0);
        chk("rst_mem_read", mem_read,     32'd0);
        chk("rst_mem_wr",   mem_wr,       32'd0);
        chk("rst_mem_addr", mem_addr,     32'd0);
        chk("rst_r0_rvalid", r0_if.rvalid, 32'd0);
        @(posedge clk); #1;
        drive(idle);
        rst = 1'b0;

        foreach (tbl[i]) step(tbl[i]);

        // Reset the cycle after a grant: response discarded, pointer back to r0
        step(mk(1,0,10,0, 0,0,0,0, 1,0,0,1, 10,0));
        @(posedge clk); #1;
        drive(mk(1,0,2,0, 1,0,4,0, 0,0,0,0, 0,0));
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_r0_rvalid", r0_if.rvalid, 32'd0);
        chk("mid_rst_r0_rdata",  r0_if.rdata,  32'd0);
        chk("mid_rst_r0_gnt",    r0_if.gnt,    32'd0);
        chk("mid_rst_mem_read",  mem_read,     32'd0);
        chk("mid_rst_mem_addr",  mem_addr,     32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        drive(idle);
        step(mk(1,0,2,0, 1,0,4,0, 1,0,0,1, 2,0));
        step(idle);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
